key_sched_ctrl: RTL

//  Iterative AES-128 key-expansion controller. Accepts a cipher key and drives one
//  gen_rnd_key instance for rounds 1..10, one round per clock. Stores all 11 round

---
 rtl/aes_pkg.sv | 84 ++++++++
 rtl/key_sched_ctrl_if.sv | 41 ++++
 rtl/gen_rnd_key.sv | 31 +++
 rtl/key_sched_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, controller state encoding and the
// GF(2^8) helpers used by the round-key generator.
package aes_pkg;

  localparam int KEY_W   = 128;
  localparam int NUM_RND = 10;
  localparam int AW      = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] gf_inv(
    input logic [7:0] a
  );
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] x;
    x = gf_inv(a);
    return x
         ^ {x[6:0], x[7]}
         ^ {x[5:0], x[7:6]}
         ^ {x[4:0], x[7:5]}
         ^ {x[3:0], x[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/key_sched_ctrl_if.sv
// Key-load handshake, status and round-key read port
// between the loader, the controller and the round stages.
interface key_sched_ctrl_if #(
  parameter int AW = aes_pkg::AW
);

  logic                      key_valid;
  logic                      key_ready;
  logic [aes_pkg::KEY_W-1:0] key_in;
  logic                      busy;
  logic                      done;
  logic                      keys_valid;
  logic [AW-1:0]             rd_addr;
  logic [aes_pkg::KEY_W-1:0] rd_key;
  logic                      rd_err;

  modport master (
    output key_valid,
    output key_in,
    output rd_addr,
    input  key_ready,
    input  busy,
    input  done,
    input  keys_valid,
    input  rd_key,
    input  rd_err
  );

  modport slave (
    input  key_valid,
    input  key_in,
    input  rd_addr,
    output key_ready,
    output busy,
    output done,
    output keys_valid,
    output rd_key,
    output rd_err
  );

endinterface

// File: rtl/gen_rnd_key.sv
// Combinational AES-128 round-key step: derives round key
// rnd from the previous round key.
module gen_rnd_key
  import aes_pkg::*;
(
  input  logic [3:0]       rnd,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    w0 = key_in[127:96];
    w1 = key_in[95:64];
    w2 = key_in[63:32];
    w3 = key_in[31:0];
    // RotWord then SubWord, round constant in the top byte
    t  = {sbox(w3[23:16]), sbox(w3[15:8]),
          sbox(w3[7:0]),   sbox(w3[31:24])};
    t  = t ^ {rcon(rnd), 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    key_out = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// Iterative AES-128 key-expansion controller with an
// 11-entry round-key store and a registered read port.
module key_sched_ctrl #(
  parameter int NUM_RND = aes_pkg::NUM_RND,
  parameter int AW      = aes_pkg::AW
) (
  input logic             clk,
  input logic             rst,
  key_sched_ctrl_if.slave bus
);

  localparam int KW = aes_pkg::KEY_W;
  localparam logic [3:0] LAST = 4'(NUM_RND);
  localparam logic [AW-1:0] MAX_A = AW'(NUM_RND);

  aes_pkg::state_t state_q, state_d;

  logic [3:0]    rnd_q, rnd_d;
  logic [KW-1:0] prev_q, prev_d;
  logic [KW-1:0] nk;
  logic [KW-1:0] wdata;
  logic [3:0]    waddr;
  logic          we;
  logic          accept;
  logic          done_q, done_d;
  logic          kv_q, kv_d;
  logic [KW-1:0] rd_key_q;
  logic          rd_err_q;
  logic          rd_ok;

  logic [KW-1:0] store [NUM_RND+1];

  gen_rnd_key u_gen (
    .rnd     (rnd_q),
    .key_in  (prev_q),
    .key_out (nk)
  );

  assign accept = bus.key_valid
               && (state_q != aes_pkg::EXPAND);
  assign rd_ok  = bus.rd_addr <= MAX_A;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    prev_d  = prev_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    we      = 1'b0;
    waddr   = rnd_q;
    wdata   = nk;
    unique case (state_q)
      aes_pkg::IDLE,
      aes_pkg::DONE: begin
        if (accept) begin
          state_d = aes_pkg::EXPAND;
          rnd_d   = 4'd1;
          prev_d  = bus.key_in;
          kv_d    = 1'b0;
          we      = 1'b1;
          waddr   = 4'd0;
          wdata   = bus.key_in;
        end
      end
      aes_pkg::EXPAND: begin
        we     = 1'b1;
        prev_d = nk;
        if (rnd_q == LAST) begin
          state_d = aes_pkg::DONE;
          rnd_d   = 4'd0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: begin
        state_d = aes_pkg::IDLE;
        rnd_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= aes_pkg::IDLE;
      rnd_q    <= 4'd0;
      prev_q   <= '0;
      done_q   <= 1'b0;
      kv_q     <= 1'b0;
      rd_key_q <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      prev_q   <= prev_d;
      done_q   <= done_d;
      kv_q     <= kv_d;
      rd_err_q <= !rd_ok;
      rd_key_q <= rd_ok ? store[bus.rd_addr] : '0;
    end
  end

  // Store is deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      store[waddr] <= wdata;
    end
  end

  assign bus.key_ready  = state_q != aes_pkg::EXPAND;
  assign bus.busy       = state_q == aes_pkg::EXPAND;
  assign bus.done       = done_q;
  assign bus.keys_valid = kv_q;
  assign bus.rd_key     = rd_key_q;
  assign bus.rd_err     = rd_err_q;

endmodule
